// File: rtl/sensor_event_fsm_if.sv
// Sensor event detector bus: raw sensor/mode/clear controls in,
// per-channel event flags, counters and saturation status out.
interface sensor_event_fsm_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 8
);
  logic [NUM_CH-1:0]           sensor;
  logic                        mode;
  logic                        count_clear;
  logic [NUM_CH-1:0]           count_flag;
  logic                        any_flag;
  logic [NUM_CH*CNT_WIDTH-1:0] event_count;
  logic [NUM_CH-1:0]           count_sat;

  modport master (
    output sensor, mode, count_clear,
    input  count_flag, any_flag, event_count, count_sat
  );

  modport slave (
    input  sensor, mode, count_clear,
    output count_flag, any_flag, event_count, count_sat
  );
endinterface

// File: rtl/sensor_event_fsm.sv
// Multi-channel sensor press detector: per-channel synchroniser, debounce FSM
// with optional auto-repeat, and saturating event counters.
module sensor_event_fsm #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic              clk,
  input  logic              reset,
  sensor_event_fsm_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DB_ON  = 3'd1;
  localparam logic [2:0] FLAG   = 3'd2;
  localparam logic [2:0] HELD   = 3'd3;
  localparam logic [2:0] DB_OFF = 3'd4;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0]      RP_LAST = RP_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]           flag;
  logic [NUM_CH-1:0]           sat;
  logic [NUM_CH*CNT_WIDTH-1:0] counts;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p;
    logic                   s;
    logic [2:0]             state, state_nxt;
    logic [DB_W-1:0]        db_cnt, db_nxt;
    logic [RP_W-1:0]        rp_cnt, rp_nxt;
    logic [CNT_WIDTH-1:0]   ev_cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_p <= '0;
      else        sync_p <= {sync_p[SYNC_STAGES-2:0], bus.sensor[i]};
    end

    assign s = sync_p[SYNC_STAGES-1];

    always_comb begin
      state_nxt = state;
      db_nxt    = db_cnt;
      rp_nxt    = rp_cnt;
      case (state)
        IDLE: begin
          if (s) begin
            state_nxt = DB_ON;
            db_nxt    = '0;
          end
        end
        DB_ON: begin
          if (!s)                  state_nxt = IDLE;
          else if (db_cnt == DB_LAST) state_nxt = FLAG;
          else                     db_nxt    = db_cnt + 1'b1;
        end
        FLAG: begin
          state_nxt = HELD;
          rp_nxt    = '0;
        end
        HELD: begin
          // A release always wins over a pending repeat pulse.
          if (!s) begin
            state_nxt = DB_OFF;
            db_nxt    = '0;
          end else if (bus.mode && rp_cnt == RP_LAST) begin
            state_nxt = FLAG;
          end else if (bus.mode) begin
            rp_nxt = rp_cnt + 1'b1;
          end else begin
            rp_nxt = '0;
          end
        end
        DB_OFF: begin
          if (s) begin
            state_nxt = HELD;
            rp_nxt    = '0;
          end else if (db_cnt == DB_LAST) begin
            state_nxt = IDLE;
          end else begin
            db_nxt = db_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        db_cnt <= '0;
        rp_cnt <= '0;
      end else begin
        state  <= state_nxt;
        db_cnt <= db_nxt;
        rp_cnt <= rp_nxt;
      end
    end

    assign flag[i] = (state == FLAG);

    // Clear takes effect first, so a coincident flag still counts once.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            ev_cnt <= '0;
      else if (bus.count_clear)              ev_cnt <= CNT_WIDTH'(flag[i]);
      else if (flag[i] && ev_cnt != CNT_MAX) ev_cnt <= ev_cnt + 1'b1;
    end

    assign sat[i]                               = (ev_cnt == CNT_MAX);
    assign counts[i*CNT_WIDTH +: CNT_WIDTH]     = ev_cnt;
  end

  assign bus.count_flag  = flag;
  assign bus.any_flag    = |flag;
  assign bus.event_count = counts;
  assign bus.count_sat   = sat;

endmodule

// File: tb/tb_sensor_event_fsm.sv
// Bench for sensor_event_fsm: directed press/glitch/repeat/saturation/reset
// scenarios plus randomized sensor activity against a run-length reference model.
module tb_sensor_event_fsm;
  localparam int NUM_CH          = 4;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int REPEAT_CYCLES   = 8;
  localparam int CNT_WIDTH       = 4;
  localparam int CNT_MAX         = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sensor_event_fsm_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  sensor_event_fsm #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel is an accepted level plus the length of the
  // current run of samples that disagree with it, a repeat timer and a flag.
  bit m_hist [NUM_CH][SYNC_STAGES];
  bit m_acc  [NUM_CH];
  int m_run  [NUM_CH];
  bit m_flag [NUM_CH];
  int m_rep  [NUM_CH];
  int m_cnt  [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < SYNC_STAGES; k++) m_hist[c][k] = 1'b0;
      m_acc[c] = 1'b0; m_run[c] = 0; m_flag[c] = 1'b0; m_rep[c] = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit s;
      bit fl;
      fl = m_flag[c];
      if (bus.count_clear)          m_cnt[c] = fl ? 1 : 0;
      else if (fl && m_cnt[c] < CNT_MAX) m_cnt[c]++;
      s = m_hist[c][SYNC_STAGES-1];
      for (int k = SYNC_STAGES-1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = bus.sensor[c];
      if (fl) begin
        m_flag[c] = 1'b0; m_rep[c] = 0; m_run[c] = 0;
      end else if (!m_acc[c]) begin
        if (s) begin
          m_run[c]++;
          if (m_run[c] == DEBOUNCE_CYCLES + 1) begin
            m_acc[c] = 1'b1; m_flag[c] = 1'b1; m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end else if (!s) begin
        m_run[c]++;
        if (m_run[c] == DEBOUNCE_CYCLES + 1) begin
          m_acc[c] = 1'b0; m_run[c] = 0;
        end
      end else if (m_run[c] > 0) begin
        m_run[c] = 0; m_rep[c] = 0;
      end else if (bus.mode) begin
        if (m_rep[c] == REPEAT_CYCLES - 1) m_flag[c] = 1'b1;
        else                               m_rep[c]++;
      end else begin
        m_rep[c] = 0;
      end
    end
  endtask

  task automatic compare(input string ph);
    logic [NUM_CH-1:0]           ef;
    logic [NUM_CH*CNT_WIDTH-1:0] ec;
    logic [NUM_CH-1:0]           es;
    for (int c = 0; c < NUM_CH; c++) begin
      ef[c] = m_flag[c];
      ec[c*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[c]);
      es[c] = (m_cnt[c] == CNT_MAX);
    end
    check_val({ph, ".count_flag"},  32'(bus.count_flag),  32'(ef));
    check_val({ph, ".any_flag"},    32'(bus.any_flag),    32'(|ef));
    check_val({ph, ".event_count"}, 32'(bus.event_count), 32'(ec));
    check_val({ph, ".count_sat"},   32'(bus.count_sat),   32'(es));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (reset) model_edge();
    #1;
    compare(ph);
  endtask

  task automatic check_reset_state(input string ph);
    check_val({ph, ".flag0"}, 32'(bus.count_flag),  32'd0);
    check_val({ph, ".any0"},  32'(bus.any_flag),    32'd0);
    check_val({ph, ".cnt0"},  32'(bus.event_count), 32'd0);
    check_val({ph, ".sat0"},  32'(bus.count_sat),   32'd0);
  endtask

  // Asserts reset between edges and checks outputs clear without waiting for a clock.
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #2;
    model_reset();
    check_reset_state("reset_async");
    repeat (cycles) step("reset_hold");
    reset = 1'b1;
  endtask

  function automatic logic [CNT_WIDTH-1:0] cnt_of(input int c);
    return bus.event_count[c*CNT_WIDTH +: CNT_WIDTH];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset           = 1'b0;
    bus.sensor      = '0;
    bus.mode        = 1'b0;
    bus.count_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_init");
    reset = 1'b1;

    // Single press, mode 0: one flag exactly after edge 6.
    bus.sensor[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step("press0");
      check_val("lat_flag0", 32'(bus.count_flag[0]), 32'(k == 6));
    end
    check_val("press0_cnt", 32'(cnt_of(0)), 32'd1);
    bus.sensor[0] = 1'b0;
    repeat (12) step("rel0");

    // Short glitch: no flag.
    bus.sensor[1] = 1'b1;
    repeat (3) step("glitch1");
    bus.sensor[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step("glitch1_low");
      check_val("glitch_flag1", 32'(bus.count_flag[1]), 32'd0);
    end
    check_val("glitch_cnt1", 32'(cnt_of(1)), 32'd0);

    // Press, then a 2-cycle dropout while held: only one flag.
    bus.sensor[1] = 1'b1;
    repeat (12) step("press1");
    bus.sensor[1] = 1'b0;
    repeat (2) step("drop1");
    bus.sensor[1] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step("drop1_back");
      check_val("dropout_flag1", 32'(bus.count_flag[1]), 32'd0);
    end
    check_val("dropout_cnt1", 32'(cnt_of(1)), 32'd1);
    bus.sensor[1] = 1'b0;
    repeat (12) step("rel1");

    // Auto-repeat on channel 2: pulses at edges 6, 15, 24, 33.
    bus.mode      = 1'b1;
    bus.sensor[2] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k == 40) bus.sensor[2] = 1'b0;
      step("repeat2");
      check_val("repeat_flag2", 32'(bus.count_flag[2]),
                32'(k == 6 || k == 15 || k == 24 || k == 33));
    end
    check_val("repeat_cnt2", 32'(cnt_of(2)), 32'd4);

    // Saturation on channel 3 via auto-repeat.
    bus.sensor[3] = 1'b1;
    repeat (150) step("sat3");
    check_val("sat_cnt3", 32'(cnt_of(3)), 32'(CNT_MAX));
    check_val("sat_flag3", 32'(bus.count_sat[3]), 32'd1);

    // Clear in the same cycle as a flag: counter restarts at 1.
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (bus.count_flag[3]) found = 1'b1;
      else step("wait_flag3");
    end
    check_val("clr_wait_flag3", 32'(found), 32'd1);
    bus.count_clear = 1'b1;
    step("clr3");
    bus.count_clear = 1'b0;
    check_val("clr_cnt3", 32'(cnt_of(3)), 32'd1);
    check_val("clr_sat3", 32'(bus.count_sat[3]), 32'd0);
    check_val("clr_cnt2", 32'(cnt_of(2)), 32'd0);
    bus.sensor[3] = 1'b0;
    bus.mode      = 1'b0;
    repeat (12) step("rel3");

    // All channels together.
    bus.sensor = '1;
    for (int k = 0; k < 10; k++) begin
      step("all");
      check_val("all_flags", 32'(bus.count_flag), (k == 6) ? 32'hF : 32'h0);
    end
    bus.sensor = '0;
    repeat (12) step("rel_all");

    // Reset during debounce, release with sensor still high.
    bus.sensor[0] = 1'b1;
    repeat (4) step("pre_reset");
    do_reset(2);
    for (int k = 0; k < 10; k++) begin
      step("post_reset");
      check_val("post_reset_flag0", 32'(bus.count_flag[0]), 32'(k == 6));
    end
    bus.sensor[0] = 1'b0;
    repeat (12) step("rel_post");

    // Randomized activity.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(5) == 0) bus.sensor[c] = ~bus.sensor[c];
      if ($urandom_range(49) == 0) bus.mode = ~bus.mode;
      bus.count_clear = ($urandom_range(39) == 0);
      if ($urandom_range(299) == 0) do_reset(1 + int'($urandom_range(2)));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sensor_event_fsm.md
Name: sensor_event_fsm

Overview:
Multi-channel sensor event detector for the ATM front-end. It synchronises and debounces NUM_CH raw sensor inputs and emits a one-cycle count_flag pulse per accepted press. An optional auto-repeat mode re-pulses while a sensor is held. Per-channel saturating event counters are provided for the downstream counting and display logic.

Parameters:
NUM_CH, 4, number of independent sensor channels
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept a level change (>=1)
REPEAT_CYCLES, 8, cycles spent in HELD between auto-repeat pulses (>=2)
CNT_WIDTH, 8, width of each per-channel event counter

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
sensor  in  NUM_CH  raw, asynchronous sensor levels (1 = active)
mode  in  1  0 = one pulse per press; 1 = auto-repeat while held
count_clear  in  1  synchronous clear of all event counters
count_flag  out  NUM_CH  one-cycle pulse per accepted event, per channel
any_flag  out  1  OR of count_flag, same cycle
event_count  out  NUM_CH*CNT_WIDTH  channel i at bits [i*CNT_WIDTH +: CNT_WIDTH]
count_sat  out  NUM_CH  channel counter is at all-ones

Behaviour:
- Reset (reset=0, async): synchronisers, states, debounce/repeat/event counters all 0. Every channel goes to IDLE. count_flag, any_flag, event_count and count_sat are all 0. Reset mid-operation aborts immediately.
- After reset release, a sensor that is already high must pass the full sync and debounce path again before it produces a flag.
- Each channel runs its own FSM on the synchronised level s. States: IDLE, DB_ON, FLAG, HELD, DB_OFF.
- IDLE: if s=1, go to DB_ON and clear the debounce counter.
- DB_ON: if s=0, go to IDLE. If s=1 and the debounce counter = DEBOUNCE_CYCLES-1, go to FLAG. Otherwise increment the counter.
- FLAG: lasts exactly one cycle; count_flag[i]=1; always goes to HELD and clears the repeat counter.
- HELD: s=0 goes to DB_OFF and clears the debounce counter; this has priority over repeat. If mode=1 and the repeat counter = REPEAT_CYCLES-1, go to FLAG. Otherwise the repeat counter increments when mode=1 and holds at 0 when mode=0.
- DB_OFF: if s=1, return to HELD and clear the repeat counter. If s=0 and the debounce counter = DEBOUNCE_CYCLES-1, go to IDLE. Otherwise increment the counter.
- Undefined state encodings go to IDLE.
- count_flag is driven only by state==FLAG (Moore). It is never high on two consecutive cycles per channel.
- Latency: take edge 0 as the first edge that samples sensor=1. count_flag rises after edge SYNC_STAGES+DEBOUNCE_CYCLES, which is edge 6 with defaults.
- Auto-repeat period = REPEAT_CYCLES+1 cycles, i.e. 9 with defaults.
- Glitch handling: a high pulse shorter than SYNC+DEBOUNCE acceptance produces no flag. A low dropout shorter than DEBOUNCE_CYCLES while HELD produces no new flag in mode 0.
- mode is sampled every cycle with no synchronisation; the source must be synchronous to clk.
- Event counter i increments by 1 on count_flag[i] and saturates at 2^CNT_WIDTH-1 with no wrap. count_sat[i] is high while the counter is all-ones.
- count_clear=1 zeroes all counters. If count_clear and count_flag[i] occur in the same cycle, counter i becomes 1 (clear then count).
- Channels are fully independent; simultaneous events on several channels each count.

Test Plan:
- Reset, then hold sensor[0]=1 from edge 0 (defaults) -> count_flag[0] high only in the cycle after edge 6; any_flag matches; event_count[0]=1; no further flags with mode=0.
- Glitch immunity: sensor[1] high for 3 cycles, then low -> no flag, counter stays 0. Later, after sensor[1] goes low, a 2-cycle low dropout during HELD -> no second flag.
- Auto-repeat: mode=1, hold sensor[2] for 40 cycles -> first flag at edge 6, then pulses every 9 cycles (edges 15, 24, 33, 42 if still HELD); the count reflects every pulse.
- Saturation and clear: CNT_WIDTH=2, 5 accepted presses -> event_count=3 and count_sat=1. Then count_clear in the same cycle as a flag -> count=1, count_sat=0.
- Simultaneous channels and reset: all 4 sensors rise together -> count_flag=4'b1111 for one cycle. Assert reset low mid-DB_ON on a second press -> outputs 0 immediately. Release reset with the sensor still high -> a new flag 6 edges later.
